prog_loader_ctrl: RTL and testbench
===================================

PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of a loaded data/instruction word.
REQ-002 Parameter ADDR_W, default 4: width of the target cache address.
REQ-003 Parameter DMEM_DEPTH, default 15: number of valid dcache entries; addresses >= DMEM_DEPTH are illegal.
REQ-004 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 Ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports: csi_in  in  1  chip select, instruction-cache load.
REQ-007 Ports: csd_in  in  1  chip select, data-cache load.
REQ-008 Ports: mosi_in  in  1  serial data, one bit per clk, MSB first.
REQ-009 Ports: run_in  in  1  level request to execute the program.
REQ-010 Ports: halt_in  in  1  processor reports program terminated (pc frozen).
REQ-011 Ports: icache_wen_out  out  1  one-cycle icache write strobe.
REQ-012 Ports: dcache_wen_out  out  1  one-cycle dcache write strobe.
REQ-013 Ports: waddr_out  out  ADDR_W  write address, valid while a strobe is high.
REQ-014 Ports: wdata_out  out  DATA_W  write data, valid while a strobe is high.
REQ-015 Ports: proc_en_out  out  1  processor run enable; low holds pc in reset.
REQ-016 Ports: busy_out  out  1  high in any state except IDLE.
REQ-017 Ports: err_out  out  1  one-cycle pulse on any frame error.
REQ-018 Ports: words_out  out  5  count of committed words, saturating at 31.

Function
REQ-019 Frame = DATA_W+ADDR_W bits (12 by default), MSB first; the first DATA_W bits are data, the last ADDR_W bits are address.
REQ-020 FSM states: IDLE, SHIFT, COMMIT, RUN.
REQ-021 IDLE: exactly one chip select high -> SHIFT; that cycle's mosi_in is sampled as bit 0; the target (I or D) is latched.
REQ-022 IDLE: both chip selects high -> err_out pulse, remain IDLE, no sample taken.
REQ-023 IDLE: no chip select and run_in=1 -> RUN; a chip select takes priority over run_in.
REQ-024 SHIFT: each cycle with the latched chip select still high, shift in mosi_in and increment the 4-bit bit counter.
REQ-025 SHIFT: after the 12th bit is sampled -> COMMIT.
REQ-026 SHIFT: latched chip select drops, or the other chip select rises, before 12 bits -> err_out pulse, discard the frame, go to IDLE, no write.
REQ-027 COMMIT, one cycle: the strobe for the latched target = 1, waddr_out = frame[3:0], wdata_out = frame[11:4]; words_out increments unless already 31.
REQ-028 COMMIT with target D and address >= DMEM_DEPTH: no strobe, err_out pulse, words_out unchanged.
REQ-029 COMMIT with the same chip select still high: sample that cycle's mosi_in as bit 0 of the next frame and go to SHIFT with counter=1 (back-to-back streaming, no gap).
REQ-030 COMMIT otherwise -> IDLE.
REQ-031 RUN: proc_en_out=1; chip selects are ignored, with an err_out pulse on the first cycle either rises.
REQ-032 RUN: run_in=0 or halt_in=1 -> IDLE; proc_en_out falls in the same registered update.
REQ-033 Entry into RUN clears words_out to 0.
REQ-034 At most one of icache_wen_out, dcache_wen_out, proc_en_out is high in any cycle.
REQ-035 All outputs are registered; the strobe appears in the cycle after the 12th bit is sampled.
REQ-036 Outside COMMIT, waddr_out and wdata_out hold their last committed value.

Reset
REQ-037 rst_n low, asynchronously: state=IDLE; counter=0; shift register=0; words_out=0; all strobes, proc_en_out, busy_out, err_out=0; waddr_out and wdata_out=0.
REQ-038 Reset asserted mid-frame or mid-run aborts with no strobe; operation resumes from IDLE on the first edge after release.

Verification
REQ-039 csi high for 12 cycles carrying 0xA53 -> icache_wen_out pulse on the next cycle, wdata_out=0xA5, waddr_out=0x3, words_out=1.
REQ-040 csd held for 24 cycles carrying 0x124 then 0x7F9 -> two dcache strobes 12 cycles apart (0x12@4, 0x7F@9), words_out=2.
REQ-041 csd frame with address 0xF -> no strobe, err_out pulse, words_out unchanged.
REQ-042 csi dropped after 7 bits -> err_out pulse, IDLE, no strobe; the next full frame loads correctly.
REQ-043 run_in=1 -> proc_en_out=1 next cycle; a csi pulse during RUN gives err_out and no strobe; halt_in=1 -> IDLE, proc_en_out=0.
REQ-044 rst_n low during bit 5 of a frame -> all outputs 0 immediately, no strobe after release.

Source files
------------

// File: rtl/prog_loader_ctrl_if.sv
// Serial load bus of the program loader.
// The loader side drives the chip selects and mosi; the controller drives the cache writes.
interface prog_loader_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              csi_in;
    logic              csd_in;
    logic              mosi_in;
    logic              icache_wen_out;
    logic              dcache_wen_out;
    logic [ADDR_W-1:0] waddr_out;
    logic [DATA_W-1:0] wdata_out;

    modport master (
        output csi_in, csd_in, mosi_in,
        input  icache_wen_out, dcache_wen_out, waddr_out, wdata_out
    );

    modport slave (
        input  csi_in, csd_in, mosi_in,
        output icache_wen_out, dcache_wen_out, waddr_out, wdata_out
    );
endinterface

// File: rtl/prog_loader_ctrl.sv
// Program loader: deserialises data+address frames into icache/dcache writes
// and gates the processor run enable.
module prog_loader_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DMEM_DEPTH = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    prog_loader_ctrl_if.slave   bus,
    input  logic                run_in,
    input  logic                halt_in,
    output logic                proc_en_out,
    output logic                busy_out,
    output logic                err_out,
    output logic [4:0]          words_out
);

    localparam int FRAME_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(DMEM_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, RUN} state_t;

    state_t             state_q, state_n;
    logic               tgt_d_q, tgt_d_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [FRAME_W-1:0] sr_q, sr_n;
    logic               cs_prev_q;
    logic               iwen_q, iwen_n;
    logic               dwen_q, dwen_n;
    logic [ADDR_W-1:0]  waddr_q, waddr_n;
    logic [DATA_W-1:0]  wdata_q, wdata_n;
    logic               err_q, err_n;
    logic [4:0]         words_q, words_n;
    logic               proc_en_q, busy_q;

    logic               cs_own, cs_oth, cs_any;
    logic [FRAME_W-1:0] sr_shift;
    logic [ADDR_W-1:0]  f_addr;
    logic [DATA_W-1:0]  f_data;

    assign cs_any   = bus.csi_in | bus.csd_in;
    assign cs_own   = tgt_d_q ? bus.csd_in : bus.csi_in;
    assign cs_oth   = tgt_d_q ? bus.csi_in : bus.csd_in;
    assign sr_shift = {sr_q[FRAME_W-2:0], bus.mosi_in};
    assign f_addr   = sr_shift[ADDR_W-1:0];
    assign f_data   = sr_shift[FRAME_W-1:ADDR_W];

    // Next state and next registered outputs.
    always_comb begin
        state_n = state_q;
        tgt_d_n = tgt_d_q;
        cnt_n   = cnt_q;
        sr_n    = sr_q;
        iwen_n  = 1'b0;
        dwen_n  = 1'b0;
        waddr_n = waddr_q;
        wdata_n = wdata_q;
        err_n   = 1'b0;
        words_n = words_q;
        unique case (state_q)
            IDLE: begin
                if (bus.csi_in && bus.csd_in) begin
                    err_n = 1'b1;
                end else if (cs_any) begin
                    state_n = SHIFT;
                    tgt_d_n = bus.csd_in;
                    sr_n    = FRAME_W'(bus.mosi_in);
                    cnt_n   = CNT_W'(1);
                end else if (run_in) begin
                    state_n = RUN;
                    words_n = 5'd0;
                end
            end
            SHIFT: begin
                if (cs_own && !cs_oth) begin
                    sr_n  = sr_shift;
                    cnt_n = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        state_n = COMMIT;
                        // Out-of-range dcache writes are dropped, not wrapped.
                        if (tgt_d_q && ({1'b0, f_addr} >= DEPTH)) begin
                            err_n = 1'b1;
                        end else begin
                            iwen_n  = !tgt_d_q;
                            dwen_n  = tgt_d_q;
                            waddr_n = f_addr;
                            wdata_n = f_data;
                            if (words_q != 5'd31) begin
                                words_n = words_q + 5'd1;
                            end
                        end
                    end
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            COMMIT: begin
                // Streaming: this cycle's bit opens the next frame.
                if (cs_own) begin
                    state_n = SHIFT;
                    sr_n    = FRAME_W'(bus.mosi_in);
                    cnt_n   = CNT_W'(1);
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (cs_any && !cs_prev_q) begin
                    err_n = 1'b1;
                end
                if (!run_in || halt_in) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_d_q   <= 1'b0;
            cnt_q     <= '0;
            sr_q      <= '0;
            cs_prev_q <= 1'b0;
            iwen_q    <= 1'b0;
            dwen_q    <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            words_q   <= 5'd0;
            proc_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            tgt_d_q   <= tgt_d_n;
            cnt_q     <= cnt_n;
            sr_q      <= sr_n;
            cs_prev_q <= cs_any;
            iwen_q    <= iwen_n;
            dwen_q    <= dwen_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            err_q     <= err_n;
            words_q   <= words_n;
            proc_en_q <= (state_n == RUN);
            busy_q    <= (state_n != IDLE);
        end
    end

    assign bus.icache_wen_out = iwen_q;
    assign bus.dcache_wen_out = dwen_q;
    assign bus.waddr_out      = waddr_q;
    assign bus.wdata_out      = wdata_q;
    assign proc_en_out        = proc_en_q;
    assign busy_out           = busy_q;
    assign err_out            = err_q;
    assign words_out          = words_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Randomised bench for prog_loader_ctrl.
// Expectations come from a frame-level model of loads, runs and errors.
module tb_prog_loader_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run_in = 1'b0;
    logic halt_in = 1'b0;
    logic proc_en_out, busy_out, err_out;
    logic [4:0] words_out;

    prog_loader_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    prog_loader_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DMEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .run_in(run_in),
        .halt_in(halt_in),
        .proc_en_out(proc_en_out),
        .busy_out(busy_out),
        .err_out(err_out),
        .words_out(words_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    int unsigned words_m = 0;
    logic [AW-1:0] waddr_m = '0;
    logic [DW-1:0] wdata_m = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp_out(input string tag, input logic iw, input logic dw,
                           input logic er, input logic bz, input logic pe);
        chk({tag, ".flags"},
            32'({bus.icache_wen_out, bus.dcache_wen_out, err_out,
                 busy_out, proc_en_out}),
            32'({iw, dw, er, bz, pe}));
        chk({tag, ".waddr"}, 32'(bus.waddr_out), 32'(waddr_m));
        chk({tag, ".wdata"}, 32'(bus.wdata_out), 32'(wdata_m));
        chk({tag, ".words"}, 32'(words_out), words_m);
    endtask

    task automatic idle();
        bus.csi_in = 1'b0;
        bus.csd_in = 1'b0;
        bus.mosi_in = 1'($urandom);
        cyc();
        exp_out("idle", 0, 0, 0, 0, 0);
    endtask

    task automatic frame(input logic d, input logic [DW-1:0] data,
                         input logic [AW-1:0] addr);
        logic [DW+AW-1:0] f;
        f = {data, addr};
        for (int i = 0; i < DW + AW; i++) begin
            bus.csi_in = !d;
            bus.csd_in = d;
            bus.mosi_in = f[DW+AW-1-i];
            cyc();
            if (i < DW + AW - 1) begin
                exp_out("shift", 0, 0, 0, 1, 0);
            end else if (d && int'(addr) >= DEPTH) begin
                exp_out("commit_bad", 0, 0, 1, 1, 0);
            end else begin
                waddr_m = addr;
                wdata_m = data;
                if (words_m < 31) words_m++;
                exp_out("commit", !d, d, 0, 1, 0);
            end
        end
    endtask

    task automatic trunc(input logic d, input int k, input logic other);
        for (int i = 0; i < k; i++) begin
            bus.csi_in = !d;
            bus.csd_in = d;
            bus.mosi_in = 1'($urandom);
            cyc();
            exp_out("tr_shift", 0, 0, 0, 1, 0);
        end
        if (other) begin
            bus.csi_in = 1'b1;
            bus.csd_in = 1'b1;
        end else begin
            bus.csi_in = 1'b0;
            bus.csd_in = 1'b0;
        end
        cyc();
        exp_out("tr_abort", 0, 0, 1, 0, 0);
        idle();
    endtask

    task automatic both_cs();
        bus.csi_in = 1'b1;
        bus.csd_in = 1'b1;
        cyc();
        exp_out("both_cs", 0, 0, 1, 0, 0);
        idle();
    endtask

    task automatic run_ep(input int n, input logic use_halt, input int pct);
        logic prev, now;
        run_in = 1'b1;
        bus.csi_in = 1'b0;
        bus.csd_in = 1'b0;
        cyc();
        words_m = 0;
        exp_out("run_in", 0, 0, 0, 1, 1);
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.csi_in = ($urandom_range(0, 99) < pct);
            bus.csd_in = ($urandom_range(0, 99) < pct);
            bus.mosi_in = 1'($urandom);
            now = bus.csi_in | bus.csd_in;
            cyc();
            exp_out("run", 0, 0, now & !prev, 1, 1);
            prev = now;
        end
        bus.csi_in = 1'b0;
        bus.csd_in = 1'b0;
        if (use_halt) halt_in = 1'b1;
        else run_in = 1'b0;
        cyc();
        exp_out("run_out", 0, 0, 0, 0, 0);
        run_in = 1'b0;
        halt_in = 1'b0;
    endtask

    initial begin
        bus.csi_in = 1'b0;
        bus.csd_in = 1'b0;
        bus.mosi_in = 1'b0;
        #1;
        exp_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        frame(1'b0, 8'hA5, 4'h3);
        idle();
        frame(1'b1, 8'h12, 4'h4);
        frame(1'b1, 8'h7F, 4'h9);
        idle();
        frame(1'b1, 8'h3C, 4'hF);
        idle();
        trunc(1'b0, 7, 1'b0);
        frame(1'b0, 8'h5A, 4'h1);
        idle();
        both_cs();
        run_ep(3, 1'b1, 0);
        bus.csi_in = 1'b0;
        run_in = 1'b1;
        cyc();
        words_m = 0;
        exp_out("run_req", 0, 0, 0, 1, 1);
        bus.csi_in = 1'b1;
        cyc();
        exp_out("run_csi", 0, 0, 1, 1, 1);
        bus.csi_in = 1'b0;
        halt_in = 1'b1;
        cyc();
        exp_out("run_halt", 0, 0, 0, 0, 0);
        run_in = 1'b0;
        halt_in = 1'b0;
        idle();

        frame(1'b0, 8'hC3, 4'h7);
        for (int i = 0; i < 5; i++) begin
            bus.csi_in = 1'b1;
            bus.mosi_in = 1'($urandom);
            cyc();
            exp_out("pre_rst", 0, 0, 0, 1, 0);
        end
        bus.mosi_in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        words_m = 0;
        waddr_m = '0;
        wdata_m = '0;
        exp_out("mid_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();

        for (int it = 0; it < 150; it++) begin
            int op;
            logic d;
            op = $urandom_range(0, 5);
            d = 1'($urandom);
            case (op)
                0, 1: begin
                    frame(d, 8'($urandom), 4'($urandom));
                    if ($urandom_range(0, 1) == 1)
                        frame(d, 8'($urandom), 4'($urandom));
                    idle();
                end
                2: trunc(d, $urandom_range(1, 11), 1'($urandom));
                3: both_cs();
                4: run_ep($urandom_range(1, 8), 1'($urandom), 30);
                default: idle();
            endcase
        end

        for (int i = 0; i < 34; i++) begin
            frame(1'b0, 8'($urandom), 4'($urandom));
        end
        idle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
